// File: rtl/fc_backprop.sv
// Backward pass of a fully-connected layer: grad_in[j] = sum_i grad_out[i]*W[i][j].
// Latency: previous_layer*next_layer MAC cycles after the start edge, then a one-cycle done pulse.
// No backpressure: start is taken only in IDLE, and grad_in holds until the next pass completes.
module fc_backprop #(
    parameter int bitwidth       = 8,
    parameter int previous_layer = 25,
    parameter int next_layer     = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic [bitwidth*next_layer-1:0]               grad_out,
    input  logic [bitwidth*previous_layer*next_layer-1:0] weights,
    output logic                                         busy,
    output logic                                         done,
    output logic [2*bitwidth*previous_layer-1:0]         grad_in
);
    localparam int PW = 2*bitwidth;
    localparam int AW = PW + $clog2(next_layer) + 1;
    localparam int IW = (next_layer > 1) ? $clog2(next_layer) : 1;
    localparam int JW = (previous_layer > 1) ? $clog2(previous_layer) : 1;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                                       state_q, state_d;
    logic [IW-1:0]                                i_q;
    logic [JW-1:0]                                j_q;
    logic signed [AW-1:0]                         acc_q;
    logic [bitwidth*next_layer-1:0]               go_q;
    logic [bitwidth*previous_layer*next_layer-1:0] w_q;
    logic [PW-1:0]                                buf_q [previous_layer];

    logic                 last_i, last_j;
    logic signed [bitwidth-1:0] g_el, w_el;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] sum;

    assign last_i = (int'(i_q) == next_layer - 1);
    assign last_j = (int'(j_q) == previous_layer - 1);

    always_comb begin
        g_el = go_q[int'(i_q)*bitwidth +: bitwidth];
        w_el = w_q[(int'(i_q)*previous_layer + int'(j_q))*bitwidth +: bitwidth];
        prod = g_el * w_el;
        sum  = acc_q + AW'(prod);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MAC;
            MAC:     if (last_i && last_j) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign busy = (state_q == MAC);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            go_q    <= '0;
            w_q     <= '0;
            grad_in <= '0;
            for (int k = 0; k < previous_layer; k++) buf_q[k] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        go_q  <= grad_out;
                        w_q   <= weights;
                        i_q   <= '0;
                        j_q   <= '0;
                        acc_q <= '0;
                    end
                end
                MAC: begin
                    if (last_i) begin
                        buf_q[j_q] <= sum[PW-1:0];
                        acc_q      <= '0;
                        i_q        <= '0;
                        j_q        <= j_q + JW'(1);
                    end else begin
                        acc_q <= sum;
                        i_q   <= i_q + IW'(1);
                    end
                    // The final entry bypasses the buffer so grad_in is already
                    // valid in the cycle where done is high.
                    if (last_i && last_j) begin
                        for (int k = 0; k < previous_layer - 1; k++)
                            grad_in[k*PW +: PW] <= buf_q[k];
                        grad_in[(previous_layer-1)*PW +: PW] <= sum[PW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_backprop.sv
// Randomized scoreboard bench for fc_backprop (25x2 default instance plus a 1x1 instance).
module tb_fc_backprop;
    localparam int BW = 8;
    localparam int P  = 25;
    localparam int N  = 2;
    localparam int PN = P*N;
    localparam int GW = 2*BW*P;

    typedef logic [GW-1:0]       gvec_t;
    typedef logic [BW*N-1:0]     ovec_t;
    typedef logic [BW*P*N-1:0]   wvec_t;
    typedef struct { int s; gvec_t exp; } pass_t;

    logic  clk = 1'b0;
    logic  rst_n, start, busy, done;
    ovec_t grad_out;
    wvec_t weights;
    gvec_t grad_in;

    logic        start1, busy1, done1;
    logic [7:0]  grad_out1, weights1;
    logic [15:0] grad_in1;

    pass_t sb[$];
    gvec_t last_grad;
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    bit    mon_en = 1'b0;

    fc_backprop #(.bitwidth(BW), .previous_layer(P), .next_layer(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .grad_out(grad_out),
        .weights(weights), .busy(busy), .done(done), .grad_in(grad_in)
    );

    fc_backprop #(.bitwidth(8), .previous_layer(1), .next_layer(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .grad_out(grad_out1),
        .weights(weights1), .busy(busy1), .done(done1), .grad_in(grad_in1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic gvec_t model(input ovec_t g, input wvec_t w);
        gvec_t r;
        int    acc;
        logic signed [BW-1:0] a, b;
        r = '0;
        for (int j = 0; j < P; j++) begin
            acc = 0;
            for (int i = 0; i < N; i++) begin
                a = g[i*BW +: BW];
                b = w[(i*P+j)*BW +: BW];
                acc += int'(a) * int'(b);
            end
            r[j*2*BW +: 2*BW] = acc[2*BW-1:0];
        end
        return r;
    endfunction

    function automatic wvec_t rnd_w();
        wvec_t w;
        for (int k = 0; k < PN; k++) w[k*BW +: BW] = 8'($urandom);
        return w;
    endfunction

    task automatic chk(input string name, input gvec_t act, input gvec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: busy/done/grad_in every cycle against the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            logic eb, ed;
            eb = (sb.size() > 0) && (cyc >= sb[0].s) && (cyc < sb[0].s + PN);
            ed = (sb.size() > 0) && (cyc == sb[0].s + PN);
            chk("busy", gvec_t'(busy), gvec_t'(eb));
            chk("done", gvec_t'(done), gvec_t'(ed));
            if (ed) begin
                chk("grad_in", grad_in, sb[0].exp);
                last_grad = sb[0].exp;
                void'(sb.pop_front());
            end else begin
                chk("grad_in_hold", grad_in, last_grad);
            end
        end
    end

    task automatic issue(input ovec_t g, input wvec_t w);
        @(posedge clk); #2;
        grad_out = g;
        weights  = w;
        start    = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{s: cyc, exp: model(g, w)});
        #1 start = 1'b0;
    endtask

    // Wait out a pass; optionally scramble inputs and inject a start at cycle inj.
    task automatic finish_pass(input bit scramble, input int inj);
        for (int k = 1; k <= PN + 1; k++) begin
            @(posedge clk); #2;
            start = (k == inj);
            if (scramble || k == inj) begin
                grad_out = ovec_t'($urandom);
                weights  = rnd_w();
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ovec_t g;
        wvec_t w;
        logic signed [7:0] a1, b1;
        int s;

        rst_n = 1'b0; start = 1'b0; grad_out = '0; weights = '0;
        start1 = 1'b0; grad_out1 = '0; weights1 = '0;
        last_grad = '0;
        #3;
        chk("reset_busy", gvec_t'(busy), '0);
        chk("reset_done", gvec_t'(done), '0);
        chk("reset_grad", grad_in, '0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        // All ones
        w = '0;
        for (int k = 0; k < PN; k++) w[k*BW +: BW] = 8'd1;
        issue(16'h0101, w);
        finish_pass(1'b0, 0);
        chk("ones_elem0", gvec_t'(grad_in[15:0]), gvec_t'(16'd2));

        // -3*5 + 2*-4 = -23
        for (int j = 0; j < P; j++) begin
            w[j*BW +: BW]     = 8'd5;
            w[(P+j)*BW +: BW] = 8'hFC;
        end
        issue({8'h02, 8'hFD}, w);
        finish_pass(1'b0, 0);
        chk("neg23_elem24", gvec_t'(grad_in[24*16 +: 16]), gvec_t'(16'hFFE9));

        // Wrap: 2 * 16384 = 32768 -> 0x8000
        for (int k = 0; k < PN; k++) w[k*BW +: BW] = 8'h80;
        issue(16'h8080, w);
        finish_pass(1'b0, 0);
        chk("wrap_elem0", gvec_t'(grad_in[15:0]), gvec_t'(16'h8000));

        // Random passes with inputs scrambled mid-flight
        for (int n = 0; n < 6; n++) begin
            issue(ovec_t'($urandom), rnd_w());
            finish_pass(1'b1, 0);
        end

        // Start with other data in cycle 10 must be ignored
        issue(ovec_t'($urandom), rnd_w());
        finish_pass(1'b0, 10);

        // Reset at cycle 10 aborts the pass
        issue(ovec_t'($urandom), rnd_w());
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        last_grad = '0;
        #1;
        chk("abort_busy", gvec_t'(busy), '0);
        chk("abort_done", gvec_t'(done), '0);
        chk("abort_grad", grad_in, '0);
        @(posedge clk); #2 rst_n = 1'b1;
        for (int k = 0; k < PN; k++) w[k*BW +: BW] = 8'd1;
        issue(16'h0101, w);
        finish_pass(1'b0, 0);

        // start held high: passes back to back every PN+2 cycles
        g = ovec_t'($urandom);
        w = rnd_w();
        @(posedge clk); #2;
        grad_out = g; weights = w; start = 1'b1;
        for (int p = 0; p < 3; p++) begin
            @(posedge clk); #1;
            sb.push_back('{s: cyc, exp: model(g, w)});
            repeat (PN + 1) @(posedge clk);
        end
        #2 start = 1'b0;

        // 1x1 instance: done in cycle 2
        for (int n = 0; n < 4; n++) begin
            a1 = 8'($urandom);
            b1 = 8'($urandom);
            if (n == 0) begin a1 = 8'h80; b1 = 8'h80; end
            @(posedge clk); #2;
            grad_out1 = a1; weights1 = b1; start1 = 1'b1;
            @(posedge clk); #2 start1 = 1'b0;
            grad_out1 = 8'($urandom); weights1 = 8'($urandom);
            @(negedge clk);
            chk("x1_busy_c1", gvec_t'({busy1, done1}), gvec_t'(2'b10));
            @(negedge clk);
            s = int'(a1) * int'(b1);
            chk("x1_done_c2", gvec_t'({busy1, done1}), gvec_t'(2'b01));
            chk("x1_grad", gvec_t'(grad_in1), gvec_t'(s[15:0]));
            @(negedge clk);
            chk("x1_idle_c3", gvec_t'({busy1, done1}), gvec_t'(2'b00));
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", gvec_t'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
